// File: rtl/prbs7_pkg.sv
// rtl/prbs7_pkg.sv - shared widths, default seed and FSM state type for the PRBS7 word generator
package prbs7_pkg;

  localparam int PRBS7_W = 7;
  localparam int WORD_W  = 32;
  localparam logic [PRBS7_W-1:0] DEFAULT_SEED = 7'h7F;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [WORD_W-1:0] bit_mask(input logic [4:0] pos);
    return WORD_W'(1) << pos;
  endfunction

endpackage

// File: rtl/prbs7_gen32_if.sv
// rtl/prbs7_gen32_if.sv - control/status and word bus of the PRBS7 word generator
interface prbs7_gen32_if;
  import prbs7_pkg::*;

  logic                enable;
  logic                load_seed;
  logic [PRBS7_W-1:0]  seed;
  logic                inj_req;
  logic [4:0]          inj_pos;
  logic [15:0]         inj_period;
  logic [WORD_W-1:0]   dout;
  logic                dout_valid;
  logic                inj_busy;
  logic                seed_err;
  logic [31:0]         word_count;
  logic [15:0]         inj_total;

  modport master (
    input  enable, load_seed, seed, inj_req, inj_pos, inj_period,
    output dout, dout_valid, inj_busy, seed_err, word_count, inj_total
  );

  modport slave (
    output enable, load_seed, seed, inj_req, inj_pos, inj_period,
    input  dout, dout_valid, inj_busy, seed_err, word_count, inj_total
  );

endinterface

// File: rtl/prbs7_word_next.sv
// rtl/prbs7_word_next.sv - unrolls 32 serial PRBS7 steps from a 7-bit state into one word
module prbs7_word_next
  import prbs7_pkg::*;
(
  input  logic [PRBS7_W-1:0] state,
  output logic [WORD_W-1:0]  word
);

  logic [PRBS7_W-1:0] chain;

  // chain[0] is the oldest bit; each step emits chain[1]^chain[0] and shifts it in at the top
  always_comb begin
    chain = state;
    word  = '0;
    for (int i = 0; i < WORD_W; i++) begin
      word[i] = chain[1] ^ chain[0];
      chain   = {word[i], chain[PRBS7_W-1:1]};
    end
  end

endmodule

// File: rtl/prbs7_gen32.sv
// rtl/prbs7_gen32.sv - PRBS7 32-bit word generator with seed load, pause/resume and error injection
module prbs7_gen32
  import prbs7_pkg::*;
#(
  parameter logic [PRBS7_W-1:0] SEED = DEFAULT_SEED
)(
  input  logic           clk,
  input  logic           rst,
  prbs7_gen32_if.master  bus
);

  state_t              state;
  logic [PRBS7_W-1:0]  s;
  logic [PRBS7_W-1:0]  seed_eff;
  logic [PRBS7_W-1:0]  src_state;
  logic [WORD_W-1:0]   word;
  logic [WORD_W-1:0]   flip;
  logic [WORD_W-1:0]   dout;
  logic                dout_valid;
  logic                inj_busy;
  logic [4:0]          inj_pos_q;
  logic                seed_err;
  logic [31:0]         word_count;
  logic [15:0]         inj_total;
  logic [15:0]         per_cnt;
  logic [15:0]         per_next;
  logic                ss_hit;
  logic                per_hit;

  // a load in the same cycle as enable feeds the new seed straight into this word
  always_comb begin
    seed_eff  = (bus.seed == '0) ? DEFAULT_SEED : bus.seed;
    src_state = bus.load_seed ? seed_eff : s;
    ss_hit    = bus.enable && inj_busy;
    per_next  = per_cnt + 16'd1;
    per_hit   = bus.enable && (bus.inj_period != 16'd0) && (per_next >= bus.inj_period);
    flip      = '0;
    if (ss_hit || per_hit)
      flip = bit_mask(ss_hit ? inj_pos_q : bus.inj_pos);
  end

  prbs7_word_next u_word_next (
    .state (src_state),
    .word  (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s          <= SEED;
      dout       <= '0;
      dout_valid <= 1'b0;
      inj_busy   <= 1'b0;
      inj_pos_q  <= '0;
      seed_err   <= 1'b0;
      word_count <= '0;
      inj_total  <= '0;
      per_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.enable)  state <= RUN;
        RUN:  if (!bus.enable) state <= IDLE;
        default: state <= IDLE;
      endcase

      dout_valid <= bus.enable;
      if (bus.enable) begin
        dout       <= word ^ flip;
        s          <= word[WORD_W-1 -: PRBS7_W];
        word_count <= word_count + 32'd1;
        if ((ss_hit || per_hit) && (inj_total != 16'hFFFF))
          inj_total <= inj_total + 16'd1;
      end else if (bus.load_seed) begin
        s <= seed_eff;
      end

      if (bus.load_seed && (bus.seed == '0))
        seed_err <= 1'b1;

      if (bus.inj_period == 16'd0)
        per_cnt <= '0;
      else if (bus.enable)
        per_cnt <= per_hit ? 16'd0 : per_next;

      // a request arriving while armed (including the applying cycle) is dropped
      if (ss_hit) begin
        inj_busy <= 1'b0;
      end else if (bus.inj_req && !inj_busy) begin
        inj_busy  <= 1'b1;
        inj_pos_q <= bus.inj_pos;
      end
    end
  end

  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.inj_busy   = inj_busy;
  assign bus.seed_err   = seed_err;
  assign bus.word_count = word_count;
  assign bus.inj_total  = inj_total;

endmodule

// File: tb/tb_prbs7_gen32.sv
// tb/tb_prbs7_gen32.sv - directed self-checking bench for prbs7_gen32 against a serial PRBS7 reference
module tb_prbs7_gen32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  prbs7_gen32_if bus ();

  prbs7_gen32 #(.SEED(7'h7F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  bit          mq[$];
  logic [31:0] w;
  logic [31:0] w1;
  logic [31:0] expv;
  logic        en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // serial reference: bit stream x[n] = x[n-7] ^ x[n-6], seed bits pushed oldest first
  task automatic model_seed(input logic [6:0] sd);
    mq.delete();
    for (int i = 0; i < 7; i++) mq.push_back(sd[i]);
  endtask

  task automatic model_next(output logic [31:0] wo);
    int n;
    bit b;
    for (int i = 0; i < 32; i++) begin
      n = mq.size();
      b = mq[n-7] ^ mq[n-6];
      mq.push_back(b);
      wo[i] = b;
    end
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.load_seed  = 1'b0;
    bus.seed       = 7'h00;
    bus.inj_req    = 1'b0;
    bus.inj_pos    = 5'd0;
    bus.inj_period = 16'd0;
    w  = '0;
    w1 = '0;

    #12;
    chk("rst_dout", bus.dout, 32'h0);
    chk("rst_valid", {31'b0, bus.dout_valid}, 32'h0);
    chk("rst_busy", {31'b0, bus.inj_busy}, 32'h0);
    chk("rst_seed_err", {31'b0, bus.seed_err}, 32'h0);
    chk("rst_word_count", bus.word_count, 32'h0);
    chk("rst_inj_total", {16'b0, bus.inj_total}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // continuous run: two full periods
    model_seed(7'h7F);
    bus.enable = 1'b1;
    for (int k = 1; k <= 254; k++) begin
      tick();
      model_next(w);
      if (k == 1) begin
        w1 = w;
        chk("first_word_const", bus.dout, 32'h4F143040);
        chk("first_valid", {31'b0, bus.dout_valid}, 32'h1);
        chk("first_count", bus.word_count, 32'd1);
      end
      if (k == 128) chk("period_wrap", bus.dout, w1);
      chk("seq_word", bus.dout, w);
    end
    chk("count_254", bus.word_count, 32'd254);
    bus.enable = 1'b0;
    tick();
    chk("idle_valid", {31'b0, bus.dout_valid}, 32'h0);
    chk("idle_hold", bus.dout, w);
    chk("idle_count", bus.word_count, 32'd254);

    // random pause/resume must not skip words
    for (int k = 0; k < 40; k++) begin
      en = 1'($urandom_range(0, 1));
      bus.enable = en;
      tick();
      chk("pause_valid", {31'b0, bus.dout_valid}, {31'b0, en});
      if (en) model_next(w);
      chk("pause_word", bus.dout, w);
    end
    bus.enable = 1'b0;
    tick();

    // single-shot while running: busy for one cycle, bit 3 flipped on the next word
    bus.enable  = 1'b1;
    bus.inj_req = 1'b1;
    bus.inj_pos = 5'd3;
    tick();
    model_next(w);
    chk("ss_clean_before", bus.dout, w);
    chk("ss_busy_set", {31'b0, bus.inj_busy}, 32'h1);
    bus.inj_req = 1'b0;
    bus.inj_pos = 5'd12;
    tick();
    model_next(w);
    chk("ss_flip3", bus.dout, w ^ 32'h0000_0008);
    chk("ss_busy_clr", {31'b0, bus.inj_busy}, 32'h0);
    chk("ss_total1", {16'b0, bus.inj_total}, 32'd1);
    tick();
    model_next(w);
    chk("ss_clean_after", bus.dout, w);

    // arm in idle; second request while armed is ignored
    bus.enable  = 1'b0;
    bus.inj_req = 1'b1;
    bus.inj_pos = 5'd5;
    tick();
    chk("arm_busy", {31'b0, bus.inj_busy}, 32'h1);
    bus.inj_pos = 5'd9;
    tick();
    chk("arm_still_busy", {31'b0, bus.inj_busy}, 32'h1);
    bus.inj_req = 1'b0;
    bus.enable  = 1'b1;
    tick();
    model_next(w);
    chk("arm_flip5", bus.dout, w ^ 32'h0000_0020);
    chk("arm_total2", {16'b0, bus.inj_total}, 32'd2);
    bus.enable = 1'b0;
    tick();

    // seed load in idle
    bus.load_seed = 1'b1;
    bus.seed      = 7'h27;
    tick();
    bus.load_seed = 1'b0;
    bus.enable    = 1'b1;
    tick();
    model_seed(7'h27);
    model_next(w);
    chk("load27_word", bus.dout, w);
    chk("load27_no_err", {31'b0, bus.seed_err}, 32'h0);

    // zero seed while running: substitute 7F, load wins over advance
    bus.load_seed = 1'b1;
    bus.seed      = 7'h00;
    tick();
    chk("zseed_word", bus.dout, 32'h4F143040);
    chk("zseed_err", {31'b0, bus.seed_err}, 32'h1);
    model_seed(7'h7F);
    model_next(w);
    bus.load_seed = 1'b0;
    tick();
    model_next(w);
    chk("zseed_next", bus.dout, w);
    chk("zseed_sticky", {31'b0, bus.seed_err}, 32'h1);

    // asynchronous reset mid-run
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_dout", bus.dout, 32'h0);
    chk("arst_count", bus.word_count, 32'h0);
    chk("arst_valid", {31'b0, bus.dout_valid}, 32'h0);
    chk("arst_seed_err", {31'b0, bus.seed_err}, 32'h0);
    chk("arst_total", {16'b0, bus.inj_total}, 32'h0);
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.enable = 1'b1;
    tick();
    chk("arst_first", bus.dout, 32'h4F143040);
    chk("arst_count1", bus.word_count, 32'd1);
    model_seed(7'h7F);
    model_next(w);

    // periodic injection every 10th word at bit 30
    bus.inj_period = 16'd10;
    bus.inj_pos    = 5'd30;
    for (int k = 1; k <= 100; k++) begin
      tick();
      model_next(w);
      expv = ((k % 10) == 0) ? (w ^ 32'h4000_0000) : w;
      chk("per_word", bus.dout, expv);
    end
    chk("per_total10", {16'b0, bus.inj_total}, 32'd10);
    bus.inj_period = 16'd0;
    bus.enable     = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
